piezo_tone_driver: RTL
======================

Name: piezo_tone_driver

Overview:
- Downstream consumer of the game controller's note, miss and change-number outputs.
- Turns a 4-bit note code into a square wave for the on-board piezo.
- Overlays two fixed sound effects: a double low "miss" buzz and a single high "next problem" chime.
- Sits between the game controller and the piezo pin; free-running from the 50 MHz board clock.

Parameters:
- SIM_SHIFT, 0: right-shift applied to every half-period table value, so simulation runs faster (0 = real pitch).
- EFFECT_CYC, 5000000: length in clk cycles of each effect segment (beep on, gap, beep on, chime).

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high
- note_in  input  4  note code from game controller; level, may change on any cycle
- miss_in  input  1  one-cycle pulse: play miss effect
- change_in  input  1  one-cycle pulse: play chime effect
- piezo_out  output  1  square-wave drive to piezo
- tone_active  output  1  high while a non-silent pitch is being generated
- effect_busy  output  1  high while a miss or chime effect is in progress

Behaviour:
- Reset (async): piezo_out=0, tone_active=0, effect_busy=0, state=IDLE, half-period counter=0, effect counter=0, registered note=0.
- Half-period table at 50 MHz, indexed by selected code, in clk cycles:
  - code 0: silence
  - 1 C4=95556, 2 D4=85131, 3 E4=75843, 4 F4=71586
  - 5 G4=63776, 6 A4=56818, 7 B4=50619, 8 C5=47778
  - codes 9-15: silence
  - internal code MISS (110 Hz) = 227273; chime uses C5
  - Used value is table>>SIM_SHIFT, clamped to a minimum of 2.
  - Counter is 18 bits wide.
- Tone generator:
  - Selected code = registered note_in in IDLE; MISS during miss-buzz states; C5 in CHIME; silence in MISS_GAP.
  - On the edge where the selected code differs from the previously selected code: counter<=0, piezo_out<=0.
  - Otherwise, for a non-silent code, at counter==half-1: piezo_out toggles and counter<=0; else counter increments.
  - First rising edge of piezo_out occurs exactly `half` cycles after the change edge.
  - Silence: piezo_out forced 0, counter held at 0.
  - tone_active = selected code non-silent, registered with the same timing as the restart.
- note_in is registered once, giving 1 cycle latency to the change edge.
- Effect FSM states: IDLE, MISS_ON1, MISS_GAP, MISS_ON2, CHIME.
  - IDLE -miss_in-> MISS_ON1; IDLE -change_in-> CHIME.
  - MISS_ON1 -> MISS_GAP -> MISS_ON2 -> IDLE; CHIME -> IDLE.
  - Each segment lasts EFFECT_CYC cycles: effect counter cleared on state entry; state advances when counter==EFFECT_CYC-1.
  - effect_busy=1 in every state except IDLE, asserted the cycle after the triggering pulse.
- Simultaneous and overlapping events:
  - miss_in and change_in in the same cycle: miss wins; change is dropped.
  - miss_in during any miss state: restarts at MISS_ON1 with counter 0.
  - miss_in during CHIME: preempts to MISS_ON1.
  - change_in during a miss state or CHIME: ignored.
- note_in changes during an effect are tracked in the register but not sounded. On return to IDLE the current note_in is selected; this is a code change, so it restarts the phase.
- Reset asserted mid-effect or mid-tone: immediate return to reset values; no residual effect after release.

Test Plan:
- SIM_SHIFT=8, note_in 0->6 at cycle 10:
  - piezo_out rises at cycle 11+221 and toggles every 221 cycles.
  - tone_active=1 from cycle 11.
- note_in 6->1 mid-high-phase:
  - piezo_out drops to 0 on the change edge.
  - Next rise comes 373 cycles later.
- note_in=12 and note_in=0: piezo_out stays 0, tone_active=0.
- EFFECT_CYC=4000, SIM_SHIFT=8, note_in=3, miss_in pulse:
  - effect_busy high for 12000 cycles.
  - 887-cycle half-period for 4000 cycles, silence for 4000, 887 again for 4000.
  - Then E4 (296) resumes with a fresh phase.
- miss_in and change_in in the same cycle: miss sequence plays, no chime.
- change_in during MISS_GAP: ignored.
- miss_in at cycle 2000 of CHIME: switches to MISS_ON1 at once.
- Reset pulse in MISS_ON2: all outputs 0 immediately.
- After release with note_in=8: 186-cycle tone starts.

Source files
------------

// File: rtl/piezo_tone_driver.sv
// Piezo square-wave driver: plays the game's note code and overlays a
// double low "miss" buzz and a single high "next problem" chime.
module piezo_tone_driver #(
  parameter int SIM_SHIFT  = 0,
  parameter int EFFECT_CYC = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] note_in,
  input  logic       miss_in,
  input  logic       change_in,
  output logic       piezo_out,
  output logic       tone_active,
  output logic       effect_busy
);

  localparam logic [4:0] CODE_C5   = 5'd8;
  localparam logic [4:0] CODE_MISS = 5'd16;
  localparam int         ECW       = (EFFECT_CYC > 1) ? $clog2(EFFECT_CYC) : 1;

  typedef enum logic [2:0] {IDLE, MISS_ON1, MISS_GAP, MISS_ON2, CHIME} state_t;

  state_t          r_state;
  logic [ECW-1:0]  r_eff_cnt;
  logic            r_busy;
  logic [3:0]      r_note;
  logic [4:0]      r_prev_sel;
  logic [17:0]     r_half_cnt;
  logic            r_piezo;
  logic            r_tone;

  logic [4:0]      w_sel;
  logic            w_sel_tone;
  logic [17:0]     w_half;
  logic            w_seg_done;

  // Half-period in clk cycles at 50 MHz; silent codes return 0.
  function automatic logic [17:0] half_raw(input logic [4:0] code);
    logic [17:0] raw;
    case (code)
      5'd1:      raw = 18'd95556;
      5'd2:      raw = 18'd85131;
      5'd3:      raw = 18'd75843;
      5'd4:      raw = 18'd71586;
      5'd5:      raw = 18'd63776;
      5'd6:      raw = 18'd56818;
      5'd7:      raw = 18'd50619;
      5'd8:      raw = 18'd47778;
      CODE_MISS: raw = 18'd227273;
      default:   raw = 18'd0;
    endcase
    return raw;
  endfunction

  function automatic logic [17:0] half_used(input logic [4:0] code);
    logic [17:0] sh;
    sh = half_raw(code) >> SIM_SHIFT;
    return (sh < 18'd2) ? 18'd2 : sh;
  endfunction

  always_comb begin
    w_sel = 5'd0;
    case (r_state)
      IDLE:               w_sel = {1'b0, r_note};
      MISS_ON1, MISS_ON2: w_sel = CODE_MISS;
      CHIME:              w_sel = CODE_C5;
      default:            w_sel = 5'd0;
    endcase
  end

  assign w_sel_tone = (half_raw(w_sel) != 18'd0);
  assign w_half     = half_used(w_sel);
  assign w_seg_done = (r_eff_cnt == ECW'(EFFECT_CYC - 1));

  // Effect sequencer; a miss pulse always wins and restarts the buzz.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_eff_cnt <= '0;
      r_busy    <= 1'b0;
    end else if (miss_in) begin
      r_state   <= MISS_ON1;
      r_eff_cnt <= '0;
      r_busy    <= 1'b1;
    end else if (r_state == IDLE) begin
      if (change_in) begin
        r_state   <= CHIME;
        r_eff_cnt <= '0;
        r_busy    <= 1'b1;
      end
    end else if (w_seg_done) begin
      r_eff_cnt <= '0;
      case (r_state)
        MISS_ON1: r_state <= MISS_GAP;
        MISS_GAP: r_state <= MISS_ON2;
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end else begin
      r_eff_cnt <= r_eff_cnt + ECW'(1);
    end
  end

  // Tone generator: any change of selected code restarts the phase low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_note     <= 4'd0;
      r_prev_sel <= 5'd0;
      r_half_cnt <= 18'd0;
      r_piezo    <= 1'b0;
      r_tone     <= 1'b0;
    end else begin
      r_note <= note_in;
      if (w_sel != r_prev_sel) begin
        r_prev_sel <= w_sel;
        r_half_cnt <= 18'd0;
        r_piezo    <= 1'b0;
        r_tone     <= w_sel_tone;
      end else if (!w_sel_tone) begin
        r_half_cnt <= 18'd0;
        r_piezo    <= 1'b0;
      end else if (r_half_cnt == w_half - 18'd1) begin
        r_half_cnt <= 18'd0;
        r_piezo    <= ~r_piezo;
      end else begin
        r_half_cnt <= r_half_cnt + 18'd1;
      end
    end
  end

  assign piezo_out   = r_piezo;
  assign tone_active = r_tone;
  assign effect_busy = r_busy;

endmodule
